// File: rtl/store_buf_pkg.sv
// Shared definitions for the store buffer: access-size codes and the buffered entry layout.
// Entry fields are sized for the widest legal configuration; narrower builds leave upper bits zero.
package store_buf_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam int MAX_ADDR_W = 64;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] data;
    logic [MAX_BE_W-1:0]   be;
  } entry_t;

endpackage

// File: rtl/store_fmt.sv
// Combinational store formatter: moves store data onto its byte lanes, builds byte enables,
// clears the in-lane address bits and flags misaligned or unsupported-size requests.
module store_fmt
  import store_buf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        size_i,
  output entry_t            entry_o,
  output logic              err_o
);

  localparam int LANE_B = DATA_W / 8;
  localparam int OFF_W  = $clog2(LANE_B);

  logic [OFF_W-1:0]      off;
  logic [MAX_DATA_W-1:0] dataExt;
  logic [MAX_DATA_W-1:0] dataLow;
  logic [MAX_DATA_W-1:0] laneMask;
  logic [MAX_BE_W-1:0]   beLow;
  logic [MAX_BE_W-1:0]   beMask;
  logic                  misaligned;

  always_comb begin
    off        = addr_i[OFF_W-1:0];
    dataExt    = MAX_DATA_W'(data_i);
    laneMask   = MAX_DATA_W'({DATA_W{1'b1}});
    beMask     = MAX_BE_W'({LANE_B{1'b1}});
    dataLow    = dataExt;
    beLow      = 8'hFF;
    misaligned = 1'b0;
    case (size_i)
      SZ_B: begin
        dataLow    = dataExt & 64'h0000_0000_0000_00FF;
        beLow      = 8'h01;
        misaligned = 1'b0;
      end
      SZ_H: begin
        dataLow    = dataExt & 64'h0000_0000_0000_FFFF;
        beLow      = 8'h03;
        misaligned = off[0];
      end
      SZ_W: begin
        dataLow    = dataExt & 64'h0000_0000_FFFF_FFFF;
        beLow      = 8'h0F;
        misaligned = |off[1:0];
      end
      default: begin
        // A doubleword cannot fit a 32-bit lane, so it is always rejected there.
        dataLow    = dataExt;
        beLow      = 8'hFF;
        misaligned = (DATA_W == 32) || (|off);
      end
    endcase

    err_o         = misaligned;
    entry_o.addr  = MAX_ADDR_W'({addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}});
    entry_o.data  = (dataLow << {off, 3'b000}) & laneMask;
    entry_o.be    = (beLow << off) & beMask;
  end

endmodule

// File: rtl/store_buf.sv
// Store buffer: FIFO of formatted stores drained to memory, with optional store-to-load
// forwarding compiled in when STORE_BUF_FWD_EN is defined (fwd_* tie to zero otherwise).
module store_buf
  import store_buf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_data,
  input  logic [1:0]                 req_size,
  output logic                       req_err,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data,
  output logic [DATA_W/8-1:0]        mem_be,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic [ADDR_W-1:0]          fwd_addr,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic [DATA_W/8-1:0]        fwd_be
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t             buf_q [DEPTH];
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               reqErr_q, reqErr_d;

  entry_t             fmtEntry;
  entry_t             headEntry;
  logic               fmtErr;
  logic               reqFire;
  logic               push;
  logic               pop;
  logic               unusedBits;

  store_fmt #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fmt (
    .addr_i  (req_addr),
    .data_i  (req_data),
    .size_i  (req_size),
    .entry_o (fmtEntry),
    .err_o   (fmtErr)
  );

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign req_ready = !full;
  assign mem_valid = !empty;
  assign req_err   = reqErr_q;

  // Memory fields read as zero whenever nothing is queued, so stale slots never leak out.
  assign headEntry = buf_q[rdPtr_q];
  assign mem_addr  = mem_valid ? headEntry.addr[ADDR_W-1:0] : '0;
  assign mem_data  = mem_valid ? headEntry.data[DATA_W-1:0] : '0;
  assign mem_be    = mem_valid ? headEntry.be[BE_W-1:0]     : '0;

  assign unusedBits = ^{headEntry, fwd_addr};

  always_comb begin
    reqFire  = req_valid && req_ready;
    push     = reqFire && !fmtErr;
    pop      = mem_valid && mem_ready;
    wrPtr_d  = wrPtr_q + PTR_W'(push);
    rdPtr_d  = rdPtr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    reqErr_d = reqFire && fmtErr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      reqErr_q <= 1'b0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      reqErr_q <= reqErr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_q[wrPtr_q] <= fmtEntry;
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [MAX_ADDR_W-1:0] fwdAligned;
  logic [PTR_W-1:0]      fwdIdx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit    = 1'b0;
    fwd_data   = '0;
    fwd_be     = '0;
    fwdIdx     = '0;
    fwdAligned = MAX_ADDR_W'({fwd_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}});
    for (int i = 0; i < DEPTH; i++) begin
      fwdIdx = rdPtr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (buf_q[fwdIdx].addr == fwdAligned)) begin
        fwd_hit  = 1'b1;
        fwd_data = buf_q[fwdIdx].data[DATA_W-1:0];
        fwd_be   = buf_q[fwdIdx].be[BE_W-1:0];
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  assign fwd_be   = '0;
`endif

endmodule
